zicntr_hpm_csr: RTL and testbench

Parametrised machine counter/timer CSR unit for the rv32i core: implements mcycle, minstret, a configurable bank of mhpmcounter/mhpmevent pairs, mcountinhibit and mcounteren as 64-bit counters accessed through 32-bit lo/hi halves. It sits beside the main CSR file, decoding the same csr address and CSR-op strobes. It answers reads combinationally and commits writes and counter increments on the clock edge.

---
 rtl/zicntr_hpm_csr.sv | 199 +++++++++++++++++++
 tb/tb_zicntr_hpm_csr.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zicntr_hpm_csr.sv
// Machine counter/timer CSR unit: mcycle, minstret, mhpmcounter/mhpmevent bank,
// mcountinhibit and mcounteren. Reads are combinational; writes and counter
// increments commit on the clock edge.
// Optional feature macro: ZICNTR_USER_SHADOW_EN enables the read-only user
// shadows (cycle/instret/hpmcounter at 0xC00-0xC9F).
module zicntr_hpm_csr #(
  parameter int unsigned NUM_HPM = 4,
  parameter int unsigned HPM_W   = 40
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [11:0]        csr_i,
  input  logic [31:0]        write_data_i,
  input  logic               is_csrrw_i,
  input  logic               is_csrrs_i,
  input  logic               is_csrrc_i,
  input  logic               is_csrrwi_i,
  input  logic               is_csrrsi_i,
  input  logic               is_csrrci_i,
  input  logic               csr_no_write_i,
  input  logic [1:0]         priv_mode_i,
  input  logic               instr_retired_i,
  input  logic [NUM_HPM-1:0] hpm_event_i,
  output logic               hit_o,
  output logic [31:0]        read_data_o,
  output logic               invalid_csr_o
);

  // Keep storage arrays non-empty when no HPM counters are configured.
  localparam int unsigned HpmN    = (NUM_HPM == 0) ? 1 : NUM_HPM;
  localparam logic [63:0] HpmMask = {64{1'b1}} >> (64 - HPM_W);
  // Implemented bits of mcountinhibit/mcounteren: CY, IR and one per HPM counter.
  localparam logic [31:0] CntMask = 32'h5 | (32'((64'd1 << NUM_HPM) - 64'd1) << 3);

  logic [63:0]     cycle_q, cycle_d, instret_q, instret_d;
  logic [63:0]     hpm_q [HpmN];
  logic [63:0]     hpm_d [HpmN];
  logic [HpmN-1:0] hpm_en_q, hpm_en_d;
  logic [31:0]     inhibit_q, inhibit_d, counteren_q, counteren_d;

  logic        op, is_wr, is_set, m_priv, hpm_range;
  logic [4:0]  idx, hpm_idx;
  logic        cnt_sel, cnt_hi, evt_sel, inh_sel, en_sel, m_sel, shd_sel;
  logic [63:0] cnt_val;
  logic        evt_en;
  logic [31:0] cnt_half, reg_val, wval;
  logic        m_write;

  assign op        = is_csrrw_i | is_csrrs_i | is_csrrc_i | is_csrrwi_i | is_csrrsi_i | is_csrrci_i;
  assign is_wr     = is_csrrw_i | is_csrrwi_i;
  assign is_set    = is_csrrs_i | is_csrrsi_i;
  assign m_priv    = priv_mode_i == 2'b11;
  assign idx       = csr_i[4:0];
  assign hpm_idx   = idx - 5'd3;
  assign hpm_range = idx >= 5'd3;

  // Index 1 has no counter (0xB01/0xB81/0xC01/0xC81 are not ours).
  assign cnt_sel = (csr_i[11:8] == 4'hB) && (csr_i[6:5] == 2'b00) && (idx != 5'd1);
  assign cnt_hi  = csr_i[7];
  assign evt_sel = (csr_i[11:5] == 7'b0011001) && hpm_range;
  assign inh_sel = csr_i == 12'h320;
  assign en_sel  = csr_i == 12'h306;
  assign m_sel   = cnt_sel | evt_sel | inh_sel | en_sel;
`ifdef ZICNTR_USER_SHADOW_EN
  assign shd_sel = (csr_i[11:8] == 4'hC) && (csr_i[6:5] == 2'b00) && (idx != 5'd1);
`else
  assign shd_sel = 1'b0;
`endif

  // Look up the counter and event enable addressed by the low index bits.
  always_comb begin
    cnt_val = '0;
    evt_en  = 1'b0;
    if (idx == 5'd0) begin
      cnt_val = cycle_q;
    end else if (idx == 5'd2) begin
      cnt_val = instret_q;
    end
    for (int unsigned i = 0; i < HpmN; i++) begin
      if (i < NUM_HPM && hpm_range && hpm_idx == 5'(i)) begin
        cnt_val = hpm_q[i];
        evt_en  = hpm_en_q[i];
      end
    end
  end

  assign cnt_half = cnt_hi ? cnt_val[63:32] : cnt_val[31:0];

  // Current value of the addressed M-mode register, and the op's write value.
  always_comb begin
    reg_val = '0;
    if (cnt_sel) begin
      reg_val = cnt_half;
    end else if (evt_sel) begin
      reg_val = {31'b0, evt_en};
    end else if (inh_sel) begin
      reg_val = inhibit_q;
    end else if (en_sel) begin
      reg_val = counteren_q;
    end
    if (is_wr) begin
      wval = write_data_i;
    end else if (is_set) begin
      wval = reg_val | write_data_i;
    end else begin
      wval = reg_val & ~write_data_i;
    end
  end

  // Access decode: hit, read data, privilege / shadow legality.
  always_comb begin
    hit_o         = 1'b0;
    read_data_o   = '0;
    invalid_csr_o = 1'b0;
    m_write       = 1'b0;
    if (op && m_sel) begin
      hit_o       = 1'b1;
      read_data_o = reg_val;
      if (!csr_no_write_i) begin
        if (m_priv) begin
          m_write = 1'b1;
        end else begin
          invalid_csr_o = 1'b1;
        end
      end
    end else if (op && shd_sel) begin
      hit_o = 1'b1;
      if (!csr_no_write_i || !(m_priv || counteren_q[idx])) begin
        invalid_csr_o = 1'b1;
      end else begin
        read_data_o = cnt_half;
      end
    end
  end

  // Next state: increments gated by the old inhibit value; a write to a
  // counter half replaces that counter's increment for the cycle.
  always_comb begin
    cycle_d     = inhibit_q[0] ? cycle_q : cycle_q + 64'd1;
    instret_d   = (instr_retired_i && !inhibit_q[2]) ? instret_q + 64'd1 : instret_q;
    hpm_en_d    = hpm_en_q;
    inhibit_d   = inhibit_q;
    counteren_d = counteren_q;
    for (int unsigned i = 0; i < HpmN; i++) begin
      hpm_d[i] = hpm_q[i];
      if (i < NUM_HPM && hpm_event_i[i] && hpm_en_q[i] && !inhibit_q[3+i]) begin
        hpm_d[i] = (hpm_q[i] + 64'd1) & HpmMask;
      end
    end
    if (m_write) begin
      if (cnt_sel && idx == 5'd0) begin
        cycle_d = cnt_hi ? {wval, cycle_q[31:0]} : {cycle_q[63:32], wval};
      end
      if (cnt_sel && idx == 5'd2) begin
        instret_d = cnt_hi ? {wval, instret_q[31:0]} : {instret_q[63:32], wval};
      end
      for (int unsigned i = 0; i < HpmN; i++) begin
        if (i < NUM_HPM && hpm_range && hpm_idx == 5'(i)) begin
          if (cnt_sel) begin
            hpm_d[i] = (cnt_hi ? {wval, hpm_q[i][31:0]} : {hpm_q[i][63:32], wval}) & HpmMask;
          end
          if (evt_sel) begin
            hpm_en_d[i] = wval[0];
          end
        end
      end
      if (inh_sel) begin
        inhibit_d = wval & CntMask;
      end
      if (en_sel) begin
        counteren_d = wval & CntMask;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cycle_q     <= '0;
      instret_q   <= '0;
      hpm_en_q    <= '0;
      inhibit_q   <= '0;
      counteren_q <= '0;
      for (int unsigned i = 0; i < HpmN; i++) begin
        hpm_q[i] <= '0;
      end
    end else begin
      cycle_q     <= cycle_d;
      instret_q   <= instret_d;
      hpm_en_q    <= hpm_en_d;
      inhibit_q   <= inhibit_d;
      counteren_q <= counteren_d;
      for (int unsigned i = 0; i < HpmN; i++) begin
        hpm_q[i] <= hpm_d[i];
      end
    end
  end

endmodule

// File: tb/tb_zicntr_hpm_csr.sv
// Directed self-checking bench for zicntr_hpm_csr (NUM_HPM=4, HPM_W=40).
module tb_zicntr_hpm_csr;

  logic        clk, rst_n;
  logic [11:0] csr;
  logic [31:0] write_data;
  logic        is_csrrw, is_csrrs, is_csrrc, is_csrrwi, is_csrrsi, is_csrrci;
  logic        csr_no_write;
  logic [1:0]  priv_mode;
  logic        instr_retired;
  logic [3:0]  hpm_event;
  logic        hit, invalid_csr;
  logic [31:0] read_data;

  int checks = 0;
  int errors = 0;
  logic [31:0] rd;
  logic        hv, iv;

  zicntr_hpm_csr #(.NUM_HPM(4), .HPM_W(40)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .csr_i           (csr),
    .write_data_i    (write_data),
    .is_csrrw_i      (is_csrrw),
    .is_csrrs_i      (is_csrrs),
    .is_csrrc_i      (is_csrrc),
    .is_csrrwi_i     (is_csrrwi),
    .is_csrrsi_i     (is_csrrsi),
    .is_csrrci_i     (is_csrrci),
    .csr_no_write_i  (csr_no_write),
    .priv_mode_i     (priv_mode),
    .instr_retired_i (instr_retired),
    .hpm_event_i     (hpm_event),
    .hit_o           (hit),
    .read_data_o     (read_data),
    .invalid_csr_o   (invalid_csr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  // Drive one CSR op at a negedge, sample #1 later, hold it across one posedge.
  // kind: 0 rw, 1 rs, 2 rc, 3 rwi, 4 rsi, 5 rci.
  task automatic csr_op(input int kind, input logic [11:0] a, input logic [31:0] d,
                        input logic nw);
    csr          = a;
    write_data   = d;
    csr_no_write = nw;
    {is_csrrw, is_csrrs, is_csrrc, is_csrrwi, is_csrrsi, is_csrrci} = 6'b100000 >> kind;
    #1;
    rd = read_data;
    hv = hit;
    iv = invalid_csr;
    @(negedge clk);
    {is_csrrw, is_csrrs, is_csrrc, is_csrrwi, is_csrrsi, is_csrrci} = '0;
    csr_no_write = 1'b0;
  endtask

  task automatic csr_rd(input logic [11:0] a);
    csr_op(1, a, 32'd0, 1'b1);
  endtask

  // Returns at the negedge where reset is released; no posedge seen since.
  task automatic do_reset();
    @(negedge clk);
    rst_n         = 1'b0;
    priv_mode     = 2'b11;
    instr_retired = 1'b0;
    hpm_event     = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [11:0] addrs [7];
    addrs = '{12'hB00, 12'hB80, 12'hB02, 12'hB03, 12'h320, 12'h306, 12'h323};
    @(negedge clk);
    csr = 12'hB00;
    #1;
    checks++;
    if (hit !== 1'b0 || read_data !== 32'd0 || invalid_csr !== 1'b0) begin
      errors++;
      $display("FAIL idle_outputs hit=%b rd=%h inv=%b exp 0/0/0", hit, read_data, invalid_csr);
    end
    @(negedge clk);
    foreach (addrs[k]) begin
      csr_rd(addrs[k]);
      checks++;
      if (rd !== 32'd0 || hv !== 1'b1) begin
        errors++;
        $display("FAIL reset_value addr=%h got rd=%h hit=%b exp 0/1", addrs[k], rd, hv);
      end
    end
    csr_rd(12'hB01);
    checks++;
    if (hv !== 1'b0) begin
      errors++;
      $display("FAIL hole_b01 hit=%b exp 0", hv);
    end
  endtask

  task automatic test_cycle_count();
    do_reset();
    repeat (10) @(negedge clk);
    csr_rd(12'hB00);
    checks++;
    if (rd !== 32'd10) begin
      errors++;
      $display("FAIL cycle_after_idle got %0d exp 10", rd);
    end
    csr_rd(12'hB80);
    checks++;
    if (rd !== 32'd0) begin
      errors++;
      $display("FAIL cycle_hi_after_idle got %h exp 0", rd);
    end
  endtask

  task automatic test_carry();
    do_reset();
    csr_op(0, 12'hB00, 32'hFFFF_FFFF, 1'b0);
    @(negedge clk);
    csr_rd(12'hB00);
    checks++;
    if (rd !== 32'd0) begin
      errors++;
      $display("FAIL carry_lo got %h exp 0", rd);
    end
    csr_rd(12'hB80);
    checks++;
    if (rd !== 32'd1) begin
      errors++;
      $display("FAIL carry_hi got %h exp 1", rd);
    end
  endtask

  task automatic test_inhibit();
    do_reset();
    instr_retired = 1'b1;
    // Old inhibit (0) governs the cycle of the write: both count once.
    csr_op(0, 12'h320, 32'h5, 1'b0);
    repeat (5) @(negedge clk);
    csr_rd(12'h320);
    checks++;
    if (rd !== 32'h5) begin
      errors++;
      $display("FAIL inhibit_readback got %h exp 5", rd);
    end
    csr_rd(12'hB00);
    checks++;
    if (rd !== 32'd1) begin
      errors++;
      $display("FAIL inhibit_cycle_frozen got %0d exp 1", rd);
    end
    csr_rd(12'hB02);
    checks++;
    if (rd !== 32'd1) begin
      errors++;
      $display("FAIL inhibit_instret_frozen got %0d exp 1", rd);
    end
    csr_op(0, 12'h320, 32'h0, 1'b0);
    csr_rd(12'hB00);
    checks++;
    if (rd !== 32'd1) begin
      errors++;
      $display("FAIL uninhibit_edge got %0d exp 1", rd);
    end
    csr_rd(12'hB02);
    checks++;
    if (rd !== 32'd2) begin
      errors++;
      $display("FAIL instret_resumed got %0d exp 2", rd);
    end
    csr_rd(12'hB00);
    checks++;
    if (rd !== 32'd3) begin
      errors++;
      $display("FAIL cycle_resumed got %0d exp 3", rd);
    end
    instr_retired = 1'b0;
    csr_op(0, 12'h320, 32'hFFFF_FFFF, 1'b0);
    csr_rd(12'h320);
    checks++;
    if (rd !== 32'h0000_007D) begin
      errors++;
      $display("FAIL inhibit_mask got %h exp 0000007d", rd);
    end
  endtask

  task automatic test_hpm();
    do_reset();
    csr_op(0, 12'h323, 32'hFFFF_FFFF, 1'b0);
    csr_rd(12'h323);
    checks++;
    if (rd !== 32'd1) begin
      errors++;
      $display("FAIL hpmevent_mask got %h exp 1", rd);
    end
    hpm_event = 4'b0011;
    repeat (3) @(negedge clk);
    hpm_event = 4'b0000;
    csr_rd(12'hB03);
    checks++;
    if (rd !== 32'd3) begin
      errors++;
      $display("FAIL hpm3_count got %0d exp 3", rd);
    end
    csr_rd(12'hB04);
    checks++;
    if (rd !== 32'd0) begin
      errors++;
      $display("FAIL hpm4_disabled got %0d exp 0", rd);
    end
    csr_op(0, 12'hB83, 32'hFFFF_FFFF, 1'b0);
    csr_rd(12'hB83);
    checks++;
    if (rd !== 32'h0000_00FF) begin
      errors++;
      $display("FAIL hpm3_hi_width got %h exp 000000ff", rd);
    end
    csr_op(3, 12'hB03, 32'hFFFF_FFFF, 1'b0);
    hpm_event = 4'b0001;
    @(negedge clk);
    hpm_event = 4'b0000;
    csr_rd(12'hB03);
    checks++;
    if (rd !== 32'd0) begin
      errors++;
      $display("FAIL hpm3_wrap_lo got %h exp 0", rd);
    end
    csr_rd(12'hB83);
    checks++;
    if (rd !== 32'd0) begin
      errors++;
      $display("FAIL hpm3_wrap_hi got %h exp 0", rd);
    end
    csr_op(0, 12'hB07, 32'h1234_5678, 1'b0);
    checks++;
    if (hv !== 1'b1 || iv !== 1'b0 || rd !== 32'd0) begin
      errors++;
      $display("FAIL unimpl_hpm hit=%b inv=%b rd=%h exp 1/0/0", hv, iv, rd);
    end
    csr_rd(12'hB07);
    checks++;
    if (rd !== 32'd0) begin
      errors++;
      $display("FAIL unimpl_hpm_readback got %h exp 0", rd);
    end
  endtask

  task automatic test_write_priority();
    do_reset();
    repeat (3) @(negedge clk);
    csr_op(0, 12'hB00, 32'h100, 1'b0);
    csr_rd(12'hB00);
    checks++;
    if (rd !== 32'h100) begin
      errors++;
      $display("FAIL write_beats_inc got %h exp 100", rd);
    end
    csr_op(2, 12'hB00, 32'h1, 1'b0);
    checks++;
    if (rd !== 32'h101) begin
      errors++;
      $display("FAIL csrrc_old got %h exp 101", rd);
    end
    csr_rd(12'hB00);
    checks++;
    if (rd !== 32'h100) begin
      errors++;
      $display("FAIL csrrc_result got %h exp 100", rd);
    end
    csr_op(4, 12'hB00, 32'hF0, 1'b0);
    csr_rd(12'hB00);
    checks++;
    if (rd !== 32'h1F1) begin
      errors++;
      $display("FAIL csrrsi_result got %h exp 1f1", rd);
    end
    instr_retired = 1'b1;
    csr_op(0, 12'hB02, 32'h50, 1'b0);
    instr_retired = 1'b0;
    csr_rd(12'hB02);
    checks++;
    if (rd !== 32'h50) begin
      errors++;
      $display("FAIL instret_write_not_counted got %h exp 50", rd);
    end
  endtask

  task automatic test_priv();
    do_reset();
    repeat (2) @(negedge clk);
    priv_mode = 2'b00;
    csr_op(0, 12'hB00, 32'h1234_5678, 1'b0);
    checks++;
    if (iv !== 1'b1 || hv !== 1'b1) begin
      errors++;
      $display("FAIL umode_write inv=%b hit=%b exp 1/1", iv, hv);
    end
    csr_rd(12'hB00);
    checks++;
    if (iv !== 1'b0 || rd !== 32'd3) begin
      errors++;
      $display("FAIL umode_write_no_effect inv=%b rd=%h exp 0/3", iv, rd);
    end
    priv_mode = 2'b11;
  endtask

  task automatic test_shadow();
    do_reset();
`ifdef ZICNTR_USER_SHADOW_EN
    priv_mode = 2'b00;
    csr_rd(12'hC00);
    checks++;
    if (iv !== 1'b1 || rd !== 32'd0 || hv !== 1'b1) begin
      errors++;
      $display("FAIL shadow_denied inv=%b rd=%h hit=%b exp 1/0/1", iv, rd, hv);
    end
    priv_mode = 2'b11;
    csr_op(0, 12'h306, 32'h1, 1'b0);
    priv_mode = 2'b00;
    csr_rd(12'hC00);
    checks++;
    if (iv !== 1'b0 || rd !== 32'd2) begin
      errors++;
      $display("FAIL shadow_allowed inv=%b rd=%h exp 0/2", iv, rd);
    end
    csr_op(0, 12'hC00, 32'h0, 1'b0);
    checks++;
    if (iv !== 1'b1) begin
      errors++;
      $display("FAIL shadow_write inv=%b exp 1", iv);
    end
    csr_rd(12'hC02);
    checks++;
    if (iv !== 1'b1) begin
      errors++;
      $display("FAIL shadow_ir_denied inv=%b exp 1", iv);
    end
    priv_mode = 2'b11;
`else
    csr_rd(12'hC00);
    checks++;
    if (hv !== 1'b0 || rd !== 32'd0 || iv !== 1'b0) begin
      errors++;
      $display("FAIL shadow_absent hit=%b rd=%h inv=%b exp 0/0/0", hv, rd, iv);
    end
    csr_rd(12'hC82);
    checks++;
    if (hv !== 1'b0) begin
      errors++;
      $display("FAIL shadow_absent_hi hit=%b exp 0", hv);
    end
`endif
  endtask

  initial begin
    rst_n         = 1'b0;
    csr           = '0;
    write_data    = '0;
    {is_csrrw, is_csrrs, is_csrrc, is_csrrwi, is_csrrsi, is_csrrci} = '0;
    csr_no_write  = 1'b0;
    priv_mode     = 2'b11;
    instr_retired = 1'b0;
    hpm_event     = '0;
    test_reset();
    test_cycle_count();
    test_carry();
    test_inhibit();
    test_hpm();
    test_write_priority();
    test_priv();
    test_shadow();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
